// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the parity-protected byte memory initiator.
// Used by the RTL, the memory model and the scoreboard.
package mem_access_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 8;
   localparam int LEN_W_DEF  = 8;
   localparam int ERR_W_DEF  = 16;

   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      RD_REQ,
      RD_WAIT,
      RESP
   } state_t;

   // Even parity: the stored parity bit makes the 9-bit word XOR to zero.
   function automatic logic even_parity(input logic [DATA_W_DEF-1:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/mem_parity_chk.sv
// Splits a {parity, data} memory word and flags an even-parity mismatch.
module mem_parity_chk #(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W:0]   word,
   output logic [DATA_W-1:0] data,
   output logic              perr
);

   assign data = word[DATA_W-1:0];
   assign perr = word[DATA_W] != (^word[DATA_W-1:0]);

endmodule

// File: rtl/mem_access_ctrl.sv
// Host-side initiator: single-byte writes and burst reads to the parity memory,
// with per-beat parity checking and a saturating parity-error counter.
module mem_access_ctrl
   import mem_access_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int LEN_W  = LEN_W_DEF,
   parameter int ERR_W  = ERR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   input  logic [LEN_W-1:0]  cmd_len,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [ADDR_W-1:0] rsp_addr,
   output logic              rsp_perr,
   output logic              rsp_last,
   output logic              mem_write,
   output logic              mem_read,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W:0]   mem_rdata,
   output logic              busy,
   output logic [ERR_W-1:0]  err_count
);

   state_t            state;
   logic [ADDR_W-1:0] addr;
   logic [LEN_W-1:0]  remaining;
   logic [DATA_W-1:0] chk_data;
   logic              chk_perr;

   mem_parity_chk #(.DATA_W(DATA_W)) u_parity_chk (
      .word (mem_rdata),
      .data (chk_data),
      .perr (chk_perr)
   );

   // NOTE: every output is a flop, so the async reset clears them immediately;
   // state uses non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cmd_ready <= 1'b1;
         busy      <= 1'b0;
         addr      <= '0;
         remaining <= '0;
         mem_write <= 1'b0;
         mem_read  <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_addr  <= '0;
         rsp_perr  <= 1'b0;
         rsp_last  <= 1'b0;
         err_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  addr      <= cmd_addr;
                  remaining <= cmd_len;
                  mem_addr  <= cmd_addr;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  if (cmd_write) begin
                     mem_write <= 1'b1;
                     mem_wdata <= cmd_wdata;
                     state     <= WRITE;
                  end else begin
                     mem_read <= 1'b1;
                     state    <= RD_REQ;
                  end
               end
            end
            WRITE: begin
               mem_write <= 1'b0;
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
               state     <= IDLE;
            end
            RD_REQ: begin
               mem_read <= 1'b0;
               state    <= RD_WAIT;
            end
            // The memory presented this beat's word on the previous edge.
            RD_WAIT: begin
               rsp_data  <= chk_data;
               rsp_perr  <= chk_perr;
               rsp_addr  <= addr;
               rsp_last  <= (remaining == '0);
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  if (rsp_perr && (err_count != '1))
                     err_count <= err_count + ERR_W'(1);
                  if (rsp_last) begin
                     cmd_ready <= 1'b1;
                     busy      <= 1'b0;
                     state     <= IDLE;
                  end else begin
                     addr      <= addr + ADDR_W'(1);
                     mem_addr  <= addr + ADDR_W'(1);
                     mem_read  <= 1'b1;
                     remaining <= remaining - LEN_W'(1);
                     state     <= RD_REQ;
                  end
               end
            end
            default: begin
               mem_write <= 1'b0;
               mem_read  <= 1'b0;
               rsp_valid <= 1'b0;
               cmd_ready <= 1'b1;
               busy      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: parity memory model, response scoreboard,
// latency/throughput, address wrap, parity errors, backpressure and mid-burst reset.
module tb_mem_access_ctrl;
   import mem_access_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [15:0] cmd_addr;
   logic [7:0]  cmd_wdata, cmd_len;
   logic        rsp_valid, rsp_ready;
   logic [7:0]  rsp_data;
   logic [15:0] rsp_addr;
   logic        rsp_perr, rsp_last;
   logic        mem_write, mem_read;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [8:0]  mem_rdata;
   logic        busy;
   logic [15:0] err_count;

   mem_access_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .cmd_len   (cmd_len),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_addr  (rsp_addr),
      .rsp_perr  (rsp_perr),
      .rsp_last  (rsp_last),
      .mem_write (mem_write),
      .mem_read  (mem_read),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: registered read, parity generated on write, optional word injection.
   logic [8:0]  mem [0:65535];
   logic        inj_en = 1'b0;
   logic [15:0] inj_addr = '0;
   logic [8:0]  inj_word = '0;

   always @(posedge clk) begin
      if (mem_write) mem[mem_addr] <= {even_parity(mem_wdata), mem_wdata};
      if (inj_en)    mem[inj_addr] <= inj_word;
      if (mem_read)  mem_rdata     <= mem[mem_addr];
   end

   typedef struct {
      logic [7:0]  data;
      logic [15:0] addr;
      logic        perr;
      logic        last;
   } beat_t;

   beat_t       sb[$];
   int          beat_cyc[$];
   logic [7:0]  exp_data [logic [15:0]];
   logic        exp_perr [logic [15:0]];
   int          checks = 0;
   int          errors = 0;
   int          acc_cyc = 0;
   bit          beat_seen = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Monitor: compare each beat once, on its first visible cycle.
   always @(negedge clk) begin
      if (!rst_n) begin
         beat_seen = 1'b0;
      end else begin
         if (mem_read || mem_write)
            check("mem_rw_exclusive", {31'b0, mem_read & mem_write}, 32'd0);
         if (rsp_valid && !beat_seen) begin
            beat_seen = 1'b1;
            beat_cyc.push_back(cyc);
            check("beat_expected", {31'b0, sb.size() > 0}, 32'd1);
            if (sb.size() > 0) begin
               beat_t e;
               e = sb.pop_front();
               check("rsp_data", {24'b0, rsp_data}, {24'b0, e.data});
               check("rsp_addr", {16'b0, rsp_addr}, {16'b0, e.addr});
               check("rsp_perr", {31'b0, rsp_perr}, {31'b0, e.perr});
               check("rsp_last", {31'b0, rsp_last}, {31'b0, e.last});
            end
         end
         if (!rsp_valid) beat_seen = 1'b0;
      end
   end

   task automatic issue(input bit wr, input logic [15:0] a, input logic [7:0] d,
                        input logic [7:0] len);
      int n = 0;
      if (wr) begin
         exp_data[a] = d;
         exp_perr[a] = 1'b0;
      end else begin
         for (int i = 0; i <= int'(len); i++) begin
            beat_t e;
            logic [15:0] ai;
            ai     = a + 16'(i);
            e.data = exp_data[ai];
            e.addr = ai;
            e.perr = exp_perr[ai];
            e.last = (i == int'(len));
            sb.push_back(e);
         end
      end
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = a;
      cmd_wdata = d;
      cmd_len   = len;
      while (!cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("cmd_ready_wait", {31'b0, cmd_ready}, 32'd1);
      @(negedge clk);
      acc_cyc   = cyc;
      cmd_valid = 1'b0;
      beat_cyc.delete();
      check("cmd_ready_drop", {31'b0, cmd_ready}, 32'd0);
      check("busy_after_accept", {31'b0, busy}, 32'd1);
      check("mem_addr_issue", {16'b0, mem_addr}, {16'b0, a});
      if (wr) begin
         check("mem_write_pulse", {31'b0, mem_write}, 32'd1);
         check("mem_wdata", {24'b0, mem_wdata}, {24'b0, d});
         @(negedge clk);
         check("mem_write_end", {31'b0, mem_write}, 32'd0);
         check("cmd_ready_after_write", {31'b0, cmd_ready}, 32'd1);
      end else begin
         check("mem_read_pulse", {31'b0, mem_read}, 32'd1);
      end
   endtask

   task automatic inject(input logic [15:0] a, input logic [8:0] word, input logic perr);
      @(negedge clk);
      inj_en   = 1'b1;
      inj_addr = a;
      inj_word = word;
      @(negedge clk);
      inj_en = 1'b0;
      exp_data[a] = word[7:0];
      exp_perr[a] = perr;
   endtask

   task automatic wait_idle();
      bit done = 1'b0;
      for (int i = 0; i < 2000 && !done; i++) begin
         @(negedge clk);
         #1;
         if (sb.size() == 0 && cmd_ready) done = 1'b1;
      end
      check("burst_complete", {31'b0, done}, 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      cmd_len   = '0;
      rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("rst_mem_rw", {30'b0, mem_read, mem_write}, 32'd0);
      check("rst_err_count", {16'b0, err_count}, 32'd0);
      rst_n = 1'b1;

      // Single write then single-beat read, with first-beat latency.
      issue(1'b1, 16'h0010, 8'h5A, 8'd0);
      issue(1'b0, 16'h0010, 8'h00, 8'd0);
      wait_idle();
      check("single_beat_count", beat_cyc.size(), 32'd1);
      if (beat_cyc.size() >= 1)
         check("first_beat_latency", beat_cyc[0] - acc_cyc, 32'd2);

      // Four-beat burst, one beat every 3 cycles.
      for (int i = 0; i < 4; i++)
         issue(1'b1, 16'h0100 + 16'(i), 8'(i + 1), 8'd0);
      issue(1'b0, 16'h0100, 8'h00, 8'd3);
      wait_idle();
      check("burst_beat_count", beat_cyc.size(), 32'd4);
      if (beat_cyc.size() == 4) begin
         check("burst_latency", beat_cyc[0] - acc_cyc, 32'd2);
         for (int i = 1; i < 4; i++)
            check("beat_spacing", beat_cyc[i] - beat_cyc[i-1], 32'd3);
      end

      // Address wrap inside a burst.
      issue(1'b1, 16'hFFFF, 8'hAA, 8'd0);
      issue(1'b1, 16'h0000, 8'hBB, 8'd0);
      issue(1'b0, 16'hFFFF, 8'h00, 8'd1);
      wait_idle();

      // Corrupted and clean words planted directly in the memory.
      inject(16'h0020, 9'h100, 1'b1);
      inject(16'h0021, 9'h101, 1'b0);
      check("err_count_before", {16'b0, err_count}, 32'd0);
      issue(1'b0, 16'h0020, 8'h00, 8'd1);
      wait_idle();
      check("err_count_after", {16'b0, err_count}, 32'd1);

      // Backpressure on the second beat of a burst.
      issue(1'b0, 16'h0100, 8'h00, 8'd3);
      for (int i = 0; i < 50 && beat_cyc.size() < 2; i++) begin
         @(negedge clk);
         #1;
      end
      check("stall_reached", {31'b0, beat_cyc.size() >= 2}, 32'd1);
      rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_valid", {31'b0, rsp_valid}, 32'd1);
         check("stall_data", {24'b0, rsp_data}, 32'h02);
         check("stall_addr", {16'b0, rsp_addr}, 32'h0101);
         check("stall_no_read", {31'b0, mem_read}, 32'd0);
         check("stall_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
      wait_idle();
      check("stall_beat_count", beat_cyc.size(), 32'd4);

      // Reset while waiting for the first beat of a four-beat burst.
      issue(1'b0, 16'h0100, 8'h00, 8'd3);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
      check("mid_rst_busy", {31'b0, busy}, 32'd0);
      check("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("mid_rst_mem_rw", {30'b0, mem_read, mem_write}, 32'd0);
      check("mid_rst_mem_addr", {16'b0, mem_addr}, 32'd0);
      check("mid_rst_err_count", {16'b0, err_count}, 32'd0);
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      issue(1'b1, 16'h0030, 8'h77, 8'd0);
      issue(1'b0, 16'h0030, 8'h00, 8'd0);
      wait_idle();
      check("post_rst_beat_count", beat_cyc.size(), 32'd1);
      check("post_rst_err_count", {16'b0, err_count}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
